// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the subword load/store unit.
// Lane selection and sign handling live here so datapath and FSM agree.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [31:0] extract_load(
    input logic [31:0] word,
    input logic [2:0]  f3,
    input logic [1:0]  off
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'd0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'd0, h};
      F3_W:    r = word;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(
    input logic [31:0] word,
    input logic [31:0] wdata,
    input logic [2:0]  f3,
    input logic [1:0]  off
  );
    logic [31:0] r;
    r = word;
    case (f3)
      F3_B: r[{off, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (off[1]) r[31:16] = wdata[15:0];
        else        r[15:0]  = wdata[15:0];
      end
      F3_W:    r = wdata;
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// Combinational load extraction and store merge datapath.
// Pure lane steering; all sequencing is done by the top FSM.
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_merge,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  output logic [31:0] o_load,
  output logic [31:0] o_store
);

  assign o_load  = extract_load(i_rdata, i_funct3, i_off);
  assign o_store = merge_store(i_merge, i_wdata, i_funct3, i_off);

endmodule

// File: rtl/lsu_subword_rmw.sv
// Load/store unit adding byte/half accesses over a word-only memory.
// Subword stores are read-modify-write; the core stalls until done.
module lsu_subword_rmw
  import lsu_pkg::*;
#(
  parameter int WORD_AW     = 8,
  parameter bit RANGE_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int HI = WORD_AW + 2;

  state_e      r_state;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_merge;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_illegal;
  logic        w_misal;
  logic        w_oor;
  logic        w_bad;
  logic        w_mem_on;
  logic [31:0] w_load;
  logic [31:0] w_store;

  always_comb begin
    w_illegal = 1'b0;
    w_misal   = 1'b0;
    unique case (1'b1)
      (req_funct3 == F3_B): w_misal = 1'b0;
      (req_funct3 == F3_H): w_misal = req_addr[0];
      (req_funct3 == F3_W): w_misal = |req_addr[1:0];
      (req_funct3 == F3_BU): w_illegal = req_we;
      (req_funct3 == F3_HU): begin
        w_illegal = req_we;
        w_misal   = req_addr[0];
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_oor = RANGE_CHECK && (|req_addr[31:HI]);
  assign w_bad = w_illegal | w_misal | w_oor;

  lsu_lane_mux u_lane (
    .i_rdata  (mem_rdata),
    .i_merge  (r_merge),
    .i_wdata  (r_wdata),
    .i_funct3 (r_f3),
    .i_off    (r_addr[1:0]),
    .o_load   (w_load),
    .o_store  (w_store)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_merge <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_f3    <= req_funct3;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_rdata <= '0;
            r_err   <= w_bad;
            if (w_bad)
              r_state <= RESP;
            else if (req_we && req_funct3 == F3_W)
              r_state <= WR;
            else
              r_state <= RD;
          end
        end
        RD: begin
          if (r_we) begin
            r_merge <= mem_rdata;
            r_state <= WR;
          end else begin
            r_rdata <= w_load;
            r_state <= RESP;
          end
        end
        WR: r_state <= RESP;
        RESP: begin
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gate with rstn so nothing leaks out while reset is held low.
  assign req_ready  = ~rstn | (r_state == IDLE);
  assign resp_valid = rstn & (r_state == RESP);
  assign resp_rdata = resp_valid ? r_rdata : '0;
  assign resp_err   = resp_valid & r_err;
  assign mem_we     = rstn & (r_state == WR);
  assign w_mem_on   = rstn & ((r_state == RD) | (r_state == WR));
  assign mem_addr   = w_mem_on ? {r_addr[31:2], 2'b00} : '0;
  assign mem_wdata  = mem_we ? w_store : '0;
  assign stall      = req_valid & ~resp_valid;

endmodule

// File: doc/lsu_subword_rmw.md
Name: lsu_subword_rmw

Overview:
- Load/store unit between the core's execute stage and the word-only data memory (256 x 32, combinational read, word-indexed by address[9:2]).
- Adds byte/halfword loads with sign or zero extension, and byte/halfword stores done as read-modify-write.
- Flags misaligned and illegal accesses, and stalls the core until each access completes.

Parameters:
- WORD_AW, 8, word-address width; memory depth is 2**WORD_AW words.
- RANGE_CHECK, 1, when 1, a nonzero address bit above [WORD_AW+1] raises err; when 0, addresses alias.

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  reset, synchronous, active-low
- req_valid  in  1  core presents an access; held until resp_valid
- req_ready  out  1  high only in IDLE; the access is accepted when req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle pulse when the access completes
- resp_rdata  out  32  extended load data, valid with resp_valid; 0 for stores and errors
- resp_err  out  1  valid with resp_valid; misaligned, illegal funct3, or out of range
- stall  out  1  req_valid & ~resp_valid; the core freezes the PC while high
- mem_addr  out  32  {addr_q[31:2],2'b00}
- mem_we  out  1  memory write enable
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  combinational read data for mem_addr

Behaviour:
- Reset: rstn=0 at a clock edge forces IDLE and clears all internal registers. Outputs while in reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation aborts the access. No write is issued in the cycle after reset, even if reset hit in WR.
- Accept (IDLE, req_valid=1): latch we, funct3, addr, wdata into *_q.
- Decode at accept:
  - illegal = store with funct3 not in {000,001,010}, or load with funct3 not in {000,001,010,100,101}.
  - misaligned = (H/HU and addr[0]) or (W and addr[1:0]!=0).
  - oor = RANGE_CHECK and |addr[31:WORD_AW+2].
- State machine, states IDLE, RD, WR, RESP:
  - IDLE -> RESP with err_q=1 if illegal | misaligned | oor. No memory access is made.
  - IDLE -> RD for loads and for SB/SH.
  - IDLE -> WR for SW.
  - RD -> RESP for loads. Capture the extracted data from mem_rdata.
  - RD -> WR for SB/SH. Capture mem_rdata into merge_q.
  - WR -> RESP.
  - RESP -> IDLE unconditionally.
- Output timing: mem_we=1 only in WR. resp_valid=1 only in RESP. req_ready=1 only in IDLE.
- Latency in cycles, from the accept edge to resp_valid: error 1, SW 2, loads 2, SB/SH 3.
- Load extraction, with byte lane = addr_q[1:0] and half lane = addr_q[1]:
  - B: sign-extend byte[lane].
  - BU: zero-extend byte[lane].
  - H: sign-extend half[addr_q[1]].
  - HU: zero-extend half[addr_q[1]].
  - W: the whole word.
- Store merge:
  - SB replaces byte[addr_q[1:0]] of merge_q with wdata[7:0].
  - SH replaces half[addr_q[1]] with wdata[15:0].
  - SW drives wdata_q directly. Untouched lanes keep their read value.
- mem_addr holds {addr_q[31:2],2'b00} in RD and WR, and is 0 elsewhere. mem_wdata is the merged word in WR and 0 elsewhere.
- Back-to-back: after RESP the block returns to IDLE for at least one cycle. Throughput is at most one access per (latency+1) cycles.
- req_valid dropping mid-access is a core protocol violation. The access still completes as latched.
- Read data is sampled in RD only. mem_rdata is ignored in every other state.

Decomposition:
- Package lsu_pkg:
  - state enum {IDLE, RD, WR, RESP}.
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - functions extract_load(word, funct3, off) and merge_store(word, wdata, funct3, off).
- One natural sub-module, lsu_lane_mux: the combinational extraction and merge datapath. The FSM stays in the top.

Test Plan:
- Reset then idle: after rstn=0 for 2 cycles then 1 -> req_ready=1, resp_valid=0, mem_we=0 on every cycle until a request arrives.
- LB sign extension: memory word[1]=32'h0000_80FF, load funct3=000 at addr 0x5 -> resp_rdata=32'hFFFF_FF80 two cycles after accept, resp_err=0. The same access with funct3=100 -> 32'h0000_0080.
- SB read-modify-write: word[2]=32'h1122_3344, SB addr 0xA, wdata=0xAB -> a single mem_we pulse with mem_wdata=32'h11AB_3344 at mem_addr 0x8, and resp_valid three cycles after accept. A following LW at 0x8 returns 32'h11AB_3344.
- SH upper half then LH: SH addr 0x6, wdata=0x00009876 onto word[1]=32'h0000_80FF -> word becomes 32'h9876_80FF. LH at 0x6 returns 32'hFFFF_9876, and LHU returns 32'h0000_9876.
- Errors: LW at 0x3, SH at 0x1, load funct3=011, and SW at 0x400 with RANGE_CHECK=1 -> each gives resp_err=1 one cycle after accept, resp_rdata=0, and mem_we never asserts.
- Reset during SB: assert rstn=0 in the cycle the FSM is in RD -> next cycle shows IDLE, mem_we=0, and memory is unchanged.
